// File: rtl/alu_issue_if.sv
// Issue-stage bus: decode-side request with operands/forwarding sources,
// and the registered ALU drive returned to the execute stage.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        exmem_we;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_we;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  aluoperation;
  logic        illegal;

  modport master (
    output in_valid, opcode, funct, imm, rs_addr, rt_addr, rs_data, rt_data,
           exmem_we, exmem_rd, exmem_result, memwb_we, memwb_rd, memwb_result,
           flush, out_ready,
    input  in_ready, out_valid, data1, data2, aluoperation, illegal
  );

  modport slave (
    input  in_valid, opcode, funct, imm, rs_addr, rt_addr, rs_data, rt_data,
           exmem_we, exmem_rd, exmem_result, memwb_we, memwb_rd, memwb_result,
           flush, out_ready,
    output in_ready, out_valid, data1, data2, aluoperation, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the instruction, resolves operand forwarding and
// holds the result in a single-entry output register.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b1111;

  // EX/MEM is the younger result, so it wins; r0 is hardwired and never forwarded.
  function automatic logic [31:0] forward(
    input logic [4:0]  addr,
    input logic [31:0] rf,
    input logic        ex_we,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_res,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_res
  );
    logic [31:0] val;
    val = rf;
    if (addr != 5'd0) begin
      if (ex_we && ex_rd == addr)      val = ex_res;
      else if (wb_we && wb_rd == addr) val = wb_res;
    end
    return val;
  endfunction

  logic [31:0] fwd_rs, fwd_rt, sext, zext;
  logic [31:0] nxt_d1, nxt_d2;
  logic [3:0]  nxt_op;
  logic        nxt_ill;
  logic        capture;

  assign fwd_rs = forward(bus.rs_addr, bus.rs_data, bus.exmem_we, bus.exmem_rd,
                          bus.exmem_result, bus.memwb_we, bus.memwb_rd, bus.memwb_result);
  assign fwd_rt = forward(bus.rt_addr, bus.rt_data, bus.exmem_we, bus.exmem_rd,
                          bus.exmem_result, bus.memwb_we, bus.memwb_rd, bus.memwb_result);
  assign sext = {{16{bus.imm[15]}}, bus.imm};
  assign zext = {16'h0000, bus.imm};

  always_comb begin
    nxt_op  = OP_ADD;
    nxt_d1  = fwd_rs;
    nxt_d2  = fwd_rt;
    nxt_ill = 1'b0;
    unique case (bus.opcode)
      6'b000000: begin
        unique case (bus.funct)
          6'b100000, 6'b100001: nxt_op = OP_ADD;
          6'b100010, 6'b100011: nxt_op = OP_SUB;
          6'b100100:            nxt_op = OP_AND;
          6'b100101:            nxt_op = OP_OR;
          6'b100110:            nxt_op = OP_XOR;
          6'b101010:            nxt_op = OP_SLT;
          default:              nxt_ill = 1'b1;
        endcase
      end
      6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
        nxt_op = OP_ADD;
        nxt_d2 = sext;
      end
      6'b001010: begin
        nxt_op = OP_SLT;
        nxt_d2 = sext;
      end
      6'b001100: begin
        nxt_op = OP_AND;
        nxt_d2 = zext;
      end
      6'b001101: begin
        nxt_op = OP_OR;
        nxt_d2 = zext;
      end
      6'b001110: begin
        nxt_op = OP_XOR;
        nxt_d2 = zext;
      end
      6'b000100: nxt_op = OP_SUB;
      default:   nxt_ill = 1'b1;
    endcase
    if (nxt_ill) begin
      nxt_op = OP_ADD;
      nxt_d1 = 32'h0;
      nxt_d2 = 32'h0;
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side; the output stays stable while out_valid && !out_ready.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.data1        <= 32'h0;
      bus.data2        <= 32'h0;
      bus.aluoperation <= OP_ADD;
      bus.illegal      <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (capture) begin
      bus.out_valid    <= 1'b1;
      bus.data1        <= nxt_d1;
      bus.data2        <= nxt_d2;
      bus.aluoperation <= nxt_op;
      bus.illegal      <= nxt_ill;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a randomized
// run scored against a behavioural decode/forward model.
module tb_alu_issue;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_issue_if bus();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected ALU drive packed as {illegal, aluoperation, data1, data2}.
  logic [68:0] exp_q[$];

  function automatic logic [31:0] pick(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 0) return rf;
    if (bus.exmem_we && bus.exmem_rd == addr) return bus.exmem_result;
    if (bus.memwb_we && bus.memwb_rd == addr) return bus.memwb_result;
    return rf;
  endfunction

  function automatic logic [68:0] model();
    int op, fn;
    logic [31:0] a, b, se, ze, d2;
    logic [3:0] alu;
    op = int'(bus.opcode);
    fn = int'(bus.funct);
    a  = pick(bus.rs_addr, bus.rs_data);
    b  = pick(bus.rt_addr, bus.rt_data);
    se = 32'($signed(bus.imm));
    ze = 32'(bus.imm);
    if (op == 0 && fn inside {32, 33})      begin alu = 0;  d2 = b;  end
    else if (op == 0 && fn inside {34, 35}) begin alu = 1;  d2 = b;  end
    else if (op == 0 && fn == 36)           begin alu = 2;  d2 = b;  end
    else if (op == 0 && fn == 37)           begin alu = 3;  d2 = b;  end
    else if (op == 0 && fn == 38)           begin alu = 4;  d2 = b;  end
    else if (op == 0 && fn == 42)           begin alu = 15; d2 = b;  end
    else if (op inside {8, 9, 35, 43})      begin alu = 0;  d2 = se; end
    else if (op == 10)                      begin alu = 15; d2 = se; end
    else if (op == 12)                      begin alu = 2;  d2 = ze; end
    else if (op == 13)                      begin alu = 3;  d2 = ze; end
    else if (op == 14)                      begin alu = 4;  d2 = ze; end
    else if (op == 4)                       begin alu = 1;  d2 = b;  end
    else return {1'b1, 4'd0, 32'd0, 32'd0};
    return {1'b0, alu, a, d2};
  endfunction

  function automatic logic [68:0] observed();
    return {bus.illegal, bus.aluoperation, bus.data1, bus.data2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_insn(input logic [5:0] opc, input logic [5:0] fn, input logic [15:0] im,
                          input logic [4:0] ra, input logic [4:0] rb,
                          input logic [31:0] da, input logic [31:0] db);
    bus.opcode = opc;  bus.funct = fn;  bus.imm = im;
    bus.rs_addr = ra;  bus.rt_addr = rb;
    bus.rs_data = da;  bus.rt_data = db;
    bus.exmem_we = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h0;
    bus.memwb_we = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_result = 32'h0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    set_insn(6'd0, 6'd0, 16'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    #3;
    checks++;
    if (bus.out_valid !== 1'b0 || observed() !== 69'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b drive=%h want valid=0 drive=0", bus.out_valid, observed());
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_sub();
    set_insn(6'b000000, 6'b100010, 16'h0, 5'd3, 5'd4, 32'h10, 32'h3);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data1 !== 32'h10 || bus.data2 !== 32'h3 || bus.aluoperation !== 4'b0001) begin
      errors++;
      $display("FAIL sub: got v=%b d1=%h d2=%h op=%b want v=1 d1=10 d2=3 op=0001",
               bus.out_valid, bus.data1, bus.data2, bus.aluoperation);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.data1 !== 32'h10) begin
      errors++;
      $display("FAIL sub_drain: got v=%b d1=%h want v=0 d1=10", bus.out_valid, bus.data1);
    end
  endtask

  task automatic test_imm();
    set_insn(6'b001000, 6'd0, 16'hFFFF, 5'd1, 5'd2, 32'h5, 32'h7);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.data2 !== 32'hFFFF_FFFF || bus.aluoperation !== 4'b0000 || bus.data1 !== 32'h5) begin
      errors++;
      $display("FAIL addi_sext: got d1=%h d2=%h op=%b want d1=5 d2=ffffffff op=0000", bus.data1, bus.data2, bus.aluoperation);
    end
    set_insn(6'b001101, 6'd0, 16'hFFFF, 5'd1, 5'd2, 32'h5, 32'h7);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.data2 !== 32'h0000_FFFF || bus.aluoperation !== 4'b0011 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ori_zext: got v=%b d2=%h op=%b want v=1 d2=0000ffff op=0011", bus.out_valid, bus.data2, bus.aluoperation);
    end
    drain();
  endtask

  task automatic test_forward();
    set_insn(6'b000000, 6'b100000, 16'h0, 5'd5, 5'd6, 32'h11, 32'h66);
    bus.exmem_we = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'hAA;
    bus.memwb_we = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'hBB;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.exmem_result = 32'hCC;
    checks++;
    if (bus.data1 !== 32'hAA || bus.data2 !== 32'h66) begin
      errors++;
      $display("FAIL fwd_exmem_prio: got d1=%h d2=%h want d1=aa d2=66", bus.data1, bus.data2);
    end
    step();
    checks++;
    if (bus.data1 !== 32'hAA) begin
      errors++;
      $display("FAIL fwd_held: got d1=%h want aa", bus.data1);
    end
    bus.out_ready = 1'b1;
    set_insn(6'b000000, 6'b100000, 16'h0, 5'd5, 5'd6, 32'h11, 32'h66);
    bus.memwb_we = 1'b1; bus.memwb_rd = 5'd6; bus.memwb_result = 32'hBB;
    bus.exmem_we = 1'b0; bus.exmem_rd = 5'd6; bus.exmem_result = 32'hAA;
    bus.in_valid = 1'b1;
    step();
    checks++;
    if (bus.data1 !== 32'h11 || bus.data2 !== 32'hBB) begin
      errors++;
      $display("FAIL fwd_memwb: got d1=%h d2=%h want d1=11 d2=bb", bus.data1, bus.data2);
    end
    set_insn(6'b000000, 6'b100000, 16'h0, 5'd0, 5'd0, 32'h22, 32'h33);
    bus.exmem_we = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hAA;
    bus.memwb_we = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hBB;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.data1 !== 32'h22 || bus.data2 !== 32'h33) begin
      errors++;
      $display("FAIL fwd_r0: got d1=%h d2=%h want d1=22 d2=33", bus.data1, bus.data2);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [68:0] exp_a, exp_b;
    set_insn(6'b000000, 6'b100100, 16'h0, 5'd7, 5'd8, 32'h1234_5678, 32'h0F0F_0F0F);
    exp_a = model();
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    set_insn(6'b001010, 6'd0, 16'h8001, 5'd9, 5'd10, 32'hDEAD_BEEF, 32'h1);
    exp_b = model();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || observed() !== exp_a) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b drive=%h want rdy=0 v=1 drive=%h",
                 i, bus.in_ready, bus.out_valid, observed(), exp_a);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || observed() !== exp_b) begin
      errors++;
      $display("FAIL stall_next_capture: got v=%b drive=%h want v=1 drive=%h", bus.out_valid, observed(), exp_b);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    logic [68:0] exp_a;
    set_insn(6'b001110, 6'd0, 16'h00F0, 5'd1, 5'd2, 32'hFF, 32'h0);
    exp_a = model();
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    set_insn(6'b000000, 6'b100101, 16'h0, 5'd3, 5'd4, 32'hAAAA, 32'h5555);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || observed() !== exp_a) begin
      errors++;
      $display("FAIL flush: got v=%b drive=%h want v=0 drive=%h", bus.out_valid, observed(), exp_a);
    end
  endtask

  task automatic test_illegal();
    set_insn(6'b111111, 6'd0, 16'h1234, 5'd1, 5'd2, 32'h55, 32'h66);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.illegal !== 1'b1 || bus.aluoperation !== 4'b0000 || bus.data1 !== 32'h0 || bus.data2 !== 32'h0) begin
      errors++;
      $display("FAIL illegal_opcode: got ill=%b op=%b d1=%h d2=%h want ill=1 op=0000 d1=0 d2=0",
               bus.illegal, bus.aluoperation, bus.data1, bus.data2);
    end
    set_insn(6'b000000, 6'b000111, 16'h0, 5'd1, 5'd2, 32'h55, 32'h66);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.illegal !== 1'b1 || bus.data1 !== 32'h0) begin
      errors++;
      $display("FAIL illegal_funct: got ill=%b d1=%h want ill=1 d1=0", bus.illegal, bus.data1);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set_insn(6'b000000, 6'b100001, 16'h0, 5'd1, 5'd2, 32'h77, 32'h88);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || observed() !== 69'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got v=%b rdy=%b drive=%h want v=0 rdy=1 drive=0", bus.out_valid, bus.in_ready, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_insn(6'b001001, 6'd0, 16'h0004, 5'd1, 5'd2, 32'h100, 32'h0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data1 !== 32'h100 || bus.data2 !== 32'h4) begin
      errors++;
      $display("FAIL reset_first_capture: got v=%b d1=%h d2=%h want v=1 d1=100 d2=4", bus.out_valid, bus.data1, bus.data2);
    end
    drain();
  endtask

  task automatic test_random();
    int opc_tab[13] = '{0, 0, 0, 0, 8, 9, 10, 35, 43, 12, 13, 14, 4};
    int fn_tab[9]   = '{32, 33, 34, 35, 36, 37, 38, 42, 0};
    logic exp_ready, cap;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'(opc_tab[$urandom_range(0, 12)]);
      bus.funct  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'(fn_tab[$urandom_range(0, 7)]);
      bus.imm = 16'($urandom);
      bus.rs_addr = 5'($urandom_range(0, 7));
      bus.rt_addr = 5'($urandom_range(0, 7));
      bus.rs_data = $urandom;
      bus.rt_data = $urandom;
      bus.exmem_we = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 7)); bus.exmem_result = $urandom;
      bus.memwb_we = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 7)); bus.memwb_result = $urandom;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = (cyc < 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      #1;
      exp_ready = (exp_q.size() == 0) || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, bus.in_ready, exp_ready);
      end
      cap = bus.in_valid && exp_ready && !bus.flush;
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (bus.flush) exp_q.delete();
      else if (cap) exp_q.push_back(model());
      step();
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL rand_valid[%0d]: got %b want %b", cyc, bus.out_valid, exp_q.size() != 0);
      end else if (exp_q.size() != 0) begin
        checks++;
        if (observed() !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_drive[%0d]: got %h want %h", cyc, observed(), exp_q[0]);
        end
      end
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sub();
    test_imm();
    test_forward();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
